// File: rtl/ndn_tx_arbiter.sv
// ndn_tx_arbiter: shares one SPI transmit byte channel among three NDN packet sources and forwards whole packets.
// Define ARB_STRICT_PRIO_EN for fixed priority (0 > 1 > 2); otherwise the IDLE selection is round-robin.
module ndn_tx_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_valid,
   input  logic [23:0] req_byte,
   output logic [2:0]  req_ready,
   output logic        spi_tx_valid,
   output logic [7:0]  spi_tx_byte,
   output logic        spi_tx_sop,
   input  logic        spi_tx_ready,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        pkt_done
);

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      BODY,
      GAP
   } state_t;

   // Remaining-byte counts loaded on the header; a value of N means N+1 more bytes follow.
   localparam logic [15:0] INTEREST_REMAIN = 16'd15;
   localparam logic [15:0] DATA_REMAIN     = 16'd39;

   state_t      r_state;
   state_t      w_nextState;
   logic [2:0]  r_grant;
   logic [2:0]  w_nextGrant;
   logic [2:0]  w_pick;
   logic [15:0] r_count;
   logic [15:0] w_nextCount;
   logic [1:0]  w_grantIdx;
   logic        w_selValid;
   logic [7:0]  w_selByte;
   logic        w_active;
   logic        w_xfer;

`ifdef ARB_STRICT_PRIO_EN
   always_comb begin
      w_pick = 3'b000;
      if (req_valid[0])
         w_pick = 3'b001;
      else if (req_valid[1])
         w_pick = 3'b010;
      else if (req_valid[2])
         w_pick = 3'b100;
   end
`else
   logic [1:0] r_lastIdx;
   logic [1:0] w_nextLastIdx;

   // Search starts at the requester after the last one granted, wrapping 2 -> 0.
   always_comb begin
      w_pick = 3'b000;
      case (r_lastIdx)
         2'd0: begin
            if (req_valid[1])
               w_pick = 3'b010;
            else if (req_valid[2])
               w_pick = 3'b100;
            else if (req_valid[0])
               w_pick = 3'b001;
         end
         2'd1: begin
            if (req_valid[2])
               w_pick = 3'b100;
            else if (req_valid[0])
               w_pick = 3'b001;
            else if (req_valid[1])
               w_pick = 3'b010;
         end
         default: begin
            if (req_valid[0])
               w_pick = 3'b001;
            else if (req_valid[1])
               w_pick = 3'b010;
            else if (req_valid[2])
               w_pick = 3'b100;
         end
      endcase
   end

   always_comb begin
      w_nextLastIdx = r_lastIdx;
      if (r_state == GAP)
         w_nextLastIdx = w_grantIdx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_lastIdx <= 2'd2;
      else
         r_lastIdx <= w_nextLastIdx;
   end
`endif

   always_comb begin
      case (r_grant)
         3'b010:  w_grantIdx = 2'd1;
         3'b100:  w_grantIdx = 2'd2;
         default: w_grantIdx = 2'd0;
      endcase
   end

   always_comb begin
      case (w_grantIdx)
         2'd1: begin
            w_selValid = req_valid[1];
            w_selByte  = req_byte[15:8];
         end
         2'd2: begin
            w_selValid = req_valid[2];
            w_selByte  = req_byte[23:16];
         end
         default: begin
            w_selValid = req_valid[0];
            w_selByte  = req_byte[7:0];
         end
      endcase
   end

   assign w_active = (r_state == HEADER) || (r_state == BODY);
   assign w_xfer   = w_active && w_selValid && spi_tx_ready;

   // Data passes straight through from the owner while a packet is in progress.
   always_comb begin
      w_nextState  = r_state;
      w_nextGrant  = r_grant;
      w_nextCount  = r_count;
      spi_tx_valid = 1'b0;
      spi_tx_byte  = 8'h00;
      spi_tx_sop   = 1'b0;
      req_ready    = 3'b000;
      busy         = 1'b0;
      pkt_done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_nextGrant = w_pick;
               w_nextState = HEADER;
            end
         end
         HEADER: begin
            spi_tx_valid = w_selValid;
            spi_tx_byte  = w_selByte;
            spi_tx_sop   = w_selValid;
            req_ready    = r_grant & {3{spi_tx_ready}};
            busy         = 1'b1;
            if (w_xfer) begin
               w_nextCount = w_selByte[6] ? INTEREST_REMAIN : DATA_REMAIN;
               w_nextState = BODY;
            end
         end
         BODY: begin
            spi_tx_valid = w_selValid;
            spi_tx_byte  = w_selByte;
            req_ready    = r_grant & {3{spi_tx_ready}};
            busy         = 1'b1;
            if (w_xfer) begin
               if (r_count == 16'd0)
                  w_nextState = GAP;
               else
                  w_nextCount = r_count - 16'd1;
            end
         end
         GAP: begin
            pkt_done    = 1'b1;
            w_nextGrant = 3'b000;
            w_nextState = IDLE;
         end
         default: begin
            w_nextGrant = 3'b000;
            w_nextState = IDLE;
         end
      endcase
   end

   assign grant = r_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= 3'b000;
         r_count <= 16'd0;
      end else begin
         r_state <= w_nextState;
         r_grant <= w_nextGrant;
         r_count <= w_nextCount;
      end
   end

endmodule

// File: tb/tb_ndn_tx_arbiter.sv
// Testbench for ndn_tx_arbiter: table-driven single-packet scenarios plus arbitration-order and
// mid-packet reset sequences, checked byte by byte against a scoreboard of expected transfers.
`timescale 1ns/1ps
module tb_ndn_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [23:0] req_byte;
   logic [2:0]  req_ready;
   logic        spi_tx_valid;
   logic [7:0]  spi_tx_byte;
   logic        spi_tx_sop;
   logic        spi_tx_ready;
   logic [2:0]  grant;
   logic        busy;
   logic        pkt_done;

   ndn_tx_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_byte     (req_byte),
      .req_ready    (req_ready),
      .spi_tx_valid (spi_tx_valid),
      .spi_tx_byte  (spi_tx_byte),
      .spi_tx_sop   (spi_tx_sop),
      .spi_tx_ready (spi_tx_ready),
      .grant        (grant),
      .busy         (busy),
      .pkt_done     (pkt_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] data;
      int         src;
      logic       sop;
      logic       last;
   } xfer_t;

   typedef struct {
      int         src;
      logic [7:0] hdr;
      int         readyMode;
      int         stallAfter;
      int         stallCycles;
      int         expXfers;
      logic [2:0] expGrant;
   } vec_t;

   xfer_t      sbQ[$];
   logic [7:0] sendQ[3][$];
   int         sentCnt[3];
   int         stallAt[3];
   int         stallLeft[3];
   logic       stalledNow[3];
   int         readyMode;
   logic       readyPhase;
   int         checks;
   int         errors;
   logic       lastWasLast;
   int         idleRun;
   logic       seenPkt;
   logic       checkGap;
   int         xferCount;
   logic [2:0] firstGrant;
   int         pktSeq;
   vec_t       vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic clearBench();
      sbQ.delete();
      for (int n = 0; n < 3; n++) begin
         sendQ[n].delete();
         sentCnt[n]    = 0;
         stallAt[n]    = -1;
         stallLeft[n]  = 0;
         stalledNow[n] = 1'b0;
      end
      lastWasLast = 1'b0;
      idleRun     = 0;
      seenPkt     = 1'b0;
      xferCount   = 0;
   endtask

   task automatic queuePacket(input int src, input logic [7:0] hdr, input int nBytes);
      xfer_t      e;
      logic [7:0] b;
      for (int i = 0; i < nBytes; i++) begin
         b = (i == 0) ? hdr : 8'((i * 3 + src * 85 + pktSeq * 11) & 255);
         sendQ[src].push_back(b);
         e.data = b;
         e.src  = src;
         e.sop  = (i == 0);
         e.last = (i == nBytes - 1);
         sbQ.push_back(e);
      end
      pktSeq++;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      req_valid = 3'b000;
      req_byte  = 24'h000000;
      for (int n = 0; n < 3; n++) begin
         stalledNow[n] = (sentCnt[n] == stallAt[n]) && (stallLeft[n] > 0) && (sendQ[n].size() > 0);
         if (stalledNow[n])
            stallLeft[n]--;
         else if (sendQ[n].size() > 0) begin
            req_valid[n]        = 1'b1;
            req_byte[8*n +: 8]  = sendQ[n][0];
         end
      end
      case (readyMode)
         0: spi_tx_ready = 1'b1;
         1: begin
            readyPhase   = ~readyPhase;
            spi_tx_ready = readyPhase;
         end
         default: spi_tx_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic checkCycle();
      xfer_t e;
      logic  expDone;
      #1;
      expDone     = lastWasLast;
      lastWasLast = 1'b0;
      if (expDone || pkt_done)
         checkOutput("pkt_done", 32'(pkt_done), 32'(expDone));
      if (expDone)
         checkOutput("busy_in_gap", 32'(busy), 32'd0);
      if (sbQ.size() > 0 && stalledNow[sbQ[0].src]) begin
         checkOutput("stall_valid", 32'(spi_tx_valid), 32'd0);
         checkOutput("stall_grant", 32'(grant), 32'(1) << sbQ[0].src);
      end
      if (spi_tx_valid && spi_tx_ready) begin
         xferCount++;
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_xfer actual=0x%0h required=none", spi_tx_byte);
         end else begin
            e = sbQ.pop_front();
            checkOutput("xfer_byte", 32'(spi_tx_byte), 32'(e.data));
            checkOutput("xfer_grant", 32'(grant), 32'(1) << e.src);
            checkOutput("xfer_sop", 32'(spi_tx_sop), 32'(e.sop));
            checkOutput("xfer_ready", 32'(req_ready), 32'(1) << e.src);
            checkOutput("xfer_busy", 32'(busy), 32'd1);
            if (e.sop) begin
               firstGrant = grant;
               if (checkGap && seenPkt)
                  checkOutput("idle_gap", 32'(idleRun), 32'd2);
            end
            seenPkt     = 1'b1;
            lastWasLast = e.last;
         end
         idleRun = 0;
      end else
         idleRun++;
      for (int n = 0; n < 3; n++) begin
         if (req_valid[n] && req_ready[n] && sendQ[n].size() > 0) begin
            void'(sendQ[n].pop_front());
            sentCnt[n]++;
         end
      end
   endtask

   task automatic stepCycle();
      applyStimulus();
      checkCycle();
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst          = 1'b1;
      req_valid    = 3'b000;
      req_byte     = 24'h000000;
      spi_tx_ready = 1'b0;
      clearBench();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic runUntilDrained(input int budget, input string name);
      int c = 0;
      while ((sbQ.size() > 0 || lastWasLast) && c < budget) begin
         stepCycle();
         c++;
      end
      if (sbQ.size() > 0 || lastWasLast) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout actual=%0d_bytes_left required=0", name, sbQ.size());
         applyReset();
      end
   endtask

   task automatic checkAllIdle(input string name);
      checkOutput({name, "_grant"}, 32'(grant), 32'd0);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_pkt_done"}, 32'(pkt_done), 32'd0);
      checkOutput({name, "_valid"}, 32'(spi_tx_valid), 32'd0);
      checkOutput({name, "_sop"}, 32'(spi_tx_sop), 32'd0);
      checkOutput({name, "_byte"}, 32'(spi_tx_byte), 32'd0);
      checkOutput({name, "_ready"}, 32'(req_ready), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      rst          = 1'b1;
      req_valid    = 3'b000;
      req_byte     = 24'h000000;
      spi_tx_ready = 1'b0;
      readyMode    = 0;
      readyPhase   = 1'b0;
      checks       = 0;
      errors       = 0;
      pktSeq       = 0;
      checkGap     = 1'b0;
      firstGrant   = 3'b000;
      clearBench();

      vecs[0] = '{1, 8'h45, 0, -1, 0, 17, 3'b010};
      vecs[1] = '{0, 8'h05, 1, -1, 0, 41, 3'b001};
      vecs[2] = '{2, 8'h40, 0,  3, 5, 17, 3'b100};
      vecs[3] = '{0, 8'h7F, 2, -1, 0, 17, 3'b001};
      vecs[4] = '{2, 8'hBF, 2, -1, 0, 41, 3'b100};
      vecs[5] = '{1, 8'hC0, 1, 10, 2, 17, 3'b010};

      @(negedge clk);
      #1;
      checkAllIdle("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         for (int n = 0; n < 3; n++) begin
            sentCnt[n]   = 0;
            stallAt[n]   = -1;
            stallLeft[n] = 0;
         end
         readyMode              = vecs[i].readyMode;
         stallAt[vecs[i].src]   = vecs[i].stallAfter;
         stallLeft[vecs[i].src] = vecs[i].stallCycles;
         xferCount              = 0;
         firstGrant             = 3'b000;
         queuePacket(vecs[i].src, vecs[i].hdr, vecs[i].expXfers);
         runUntilDrained(400, "vector");
         checkOutput("vec_xfer_count", 32'(xferCount), 32'(vecs[i].expXfers));
         checkOutput("vec_grant", 32'(firstGrant), 32'(vecs[i].expGrant));
         stepCycle();
         checkOutput("vec_idle_grant", 32'(grant), 32'd0);
         checkOutput("vec_idle_busy", 32'(busy), 32'd0);
      end

      $display("[TB] arbitration order with all requesters continuously valid");
      applyReset();
      readyMode = 0;
      checkGap  = 1'b1;
`ifdef ARB_STRICT_PRIO_EN
      queuePacket(0, 8'h41, 17);
      queuePacket(0, 8'h42, 17);
      queuePacket(1, 8'h43, 17);
      queuePacket(1, 8'h44, 17);
      queuePacket(2, 8'h46, 17);
      queuePacket(2, 8'h47, 17);
`else
      queuePacket(0, 8'h41, 17);
      queuePacket(1, 8'h42, 17);
      queuePacket(2, 8'h43, 17);
      queuePacket(0, 8'h44, 17);
      queuePacket(1, 8'h46, 17);
      queuePacket(2, 8'h47, 17);
`endif
      runUntilDrained(600, "arbitration");
      checkGap = 1'b0;

      $display("[TB] reset in the middle of a data packet");
      applyReset();
      readyMode = 0;
      queuePacket(0, 8'h40, 17);
      runUntilDrained(200, "pre_reset");
      xferCount = 0;
      queuePacket(0, 8'h05, 41);
      c = 0;
      while (xferCount < 10 && c < 100) begin
         stepCycle();
         c++;
      end
      checkOutput("bytes_before_reset", 32'(xferCount), 32'd10);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkAllIdle("mid_reset");
      clearBench();
      @(negedge clk);
      req_valid = 3'b000;
      req_byte  = 24'h000000;
      #1;
      checkOutput("reset_no_done", 32'(pkt_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stepCycle();
      queuePacket(0, 8'h41, 17);
      queuePacket(1, 8'h42, 17);
      firstGrant = 3'b000;
      runUntilDrained(300, "post_reset");
      checkOutput("post_reset_last_owner", 32'(firstGrant), 32'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
